// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the in-order pipeline writeback with queued long-latency
// results onto the single register-file write port. The pipeline always wins;
// queued results drain into free slots in acceptance order.
// Optional build macro WB_PENDING_MASK_EN adds the pending_mask output.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pipe_wen,
  input  logic [4:0]              pipe_wa,
  input  logic                    pipe_float,
  input  logic [31:0]             pipe_wd,
  input  logic                    lu_valid,
  input  logic [4:0]              lu_wa,
  input  logic                    lu_float,
  input  logic [31:0]             lu_wd,
  output logic                    lu_ready,
  output logic                    wen,
  output logic [4:0]              wa,
  output logic [31:0]             wd,
  output logic                    floatingWB,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [63:0]             pending_mask
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [7:0] STARVE_MAX    = 8'hFF;
  localparam logic [7:0] STARVE_THRESH = 8'(STARVE_LIMIT - 1);

  logic [4:0]       memWa    [DEPTH];
  logic             memFloat [DEPTH];
  logic [31:0]      memWd    [DEPTH];

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic [7:0]       starveCnt;
  logic             stallReg;

  logic             isEmpty;
  logic             isFull;
  logic             slotFree;
  logic             drain;
  logic             accept;
  logic             push;
  logic [PTR_W-1:0] rdNext;
  logic [PTR_W-1:0] wrNext;
  logic [CNT_W-1:0] countNext;

  // Handshake and arbitration decisions for this cycle
  always_comb begin
    isEmpty   = (count == '0);
    isFull    = (count == CNT_W'(DEPTH));
    lu_ready  = reset && !isFull;
    slotFree  = !pipe_wen || (pipe_wa == 5'd0);
    drain     = slotFree && !isEmpty;
    accept    = lu_valid && lu_ready;
    push      = accept && (lu_wa != 5'd0);
    rdNext    = drain ? rdPtr + PTR_W'(1) : rdPtr;
    wrNext    = push ? wrPtr + PTR_W'(1) : wrPtr;
    countNext = count + CNT_W'(push) - CNT_W'(drain);
  end

  // Register-file write port mux: pipe first, then FIFO head, else pass-through
  always_comb begin
    wen        = 1'b0;
    wa         = 5'd0;
    wd         = 32'd0;
    floatingWB = 1'b0;
    if (reset) begin
      if (!slotFree) begin
        wen        = 1'b1;
        wa         = pipe_wa;
        wd         = pipe_wd;
        floatingWB = pipe_float;
      end else if (!isEmpty) begin
        wen        = 1'b1;
        wa         = memWa[rdPtr];
        wd         = memWd[rdPtr];
        floatingWB = memFloat[rdPtr];
      end else begin
        wen        = pipe_wen;
        wa         = pipe_wa;
        wd         = pipe_wd;
        floatingWB = pipe_float;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      rdPtr <= rdNext;
      wrPtr <= wrNext;
      count <= countNext;
    end
  end

  // FIFO payload storage; contents are don't-care while the slot is invalid
  always_ff @(posedge clock) begin
    if (push) begin
      memWa[wrPtr]    <= lu_wa;
      memFloat[wrPtr] <= lu_float;
      memWd[wrPtr]    <= lu_wd;
    end
  end

  // Starvation counter and registered stall request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starveCnt <= 8'd0;
      stallReg  <= 1'b0;
    end else if (isEmpty || drain) begin
      starveCnt <= 8'd0;
      stallReg  <= 1'b0;
    end else begin
      if (starveCnt != STARVE_MAX) starveCnt <= starveCnt + 8'd1;
      if (starveCnt >= STARVE_THRESH) stallReg <= 1'b1;
    end
  end

  assign stall_req  = stallReg;
  assign fifo_count = count;

`ifdef WB_PENDING_MASK_EN
  logic [63:0]      maskNext;
  logic [PTR_W-1:0] slot;

  // Destinations held by the post-edge FIFO contents
  always_comb begin
    maskNext = '0;
    slot     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rdNext + PTR_W'(i);
      if (CNT_W'(i) < countNext) begin
        if (push && (slot == wrPtr)) maskNext[{lu_float, lu_wa}] = 1'b1;
        else                         maskNext[{memFloat[slot], memWa[slot]}] = 1'b1;
      end
    end
  end

  // Pending-destination mask register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending_mask <= '0;
    else        pending_mask <= maskNext;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: random + directed stimulus against a queue-based reference
// model; expected port values are queued per cycle and checked by a monitor.
module tb_wb_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   pipe_wen = 1'b0;
  logic [4:0]             pipe_wa = '0;
  logic                   pipe_float = 1'b0;
  logic [31:0]            pipe_wd = '0;
  logic                   lu_valid = 1'b0;
  logic [4:0]             lu_wa = '0;
  logic                   lu_float = 1'b0;
  logic [31:0]            lu_wd = '0;
  logic                   lu_ready;
  logic                   wen;
  logic [4:0]             wa;
  logic [31:0]            wd;
  logic                   floatingWB;
  logic                   stall_req;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [63:0]            dutMask;

`ifdef WB_PENDING_MASK_EN
  logic [63:0] pending_mask;
  assign dutMask = pending_mask;
`else
  assign dutMask = '0;
`endif

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .pipe_wen(pipe_wen), .pipe_wa(pipe_wa), .pipe_float(pipe_float), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_float(lu_float), .lu_wd(lu_wd),
    .lu_ready(lu_ready), .wen(wen), .wa(wa), .wd(wd), .floatingWB(floatingWB),
    .stall_req(stall_req), .fifo_count(fifo_count)
`ifdef WB_PENDING_MASK_EN
    , .pending_mask(pending_mask)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  wa;
    logic        fl;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic        rdy;
    int          cnt;
    logic        stall;
    logic [63:0] mask;
  } rec_t;

  ent_t mq[$];
  rec_t expQ[$];
  int   runLen   = 0;
  bit   stallExp = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  bit   monEn    = 1'b0;

  function automatic logic [63:0] maskOf();
    logic [63:0] m;
    logic [5:0]  idx;
    m = '0;
`ifdef WB_PENDING_MASK_EN
    foreach (mq[i]) begin
      idx = {mq[i].fl, mq[i].wa};
      m[idx] = 1'b1;
    end
`endif
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expected outputs, advance the model
  task automatic cycle(input logic pw, input logic [4:0] pwa, input logic pf,
                       input logic [31:0] pwd, input logic lv, input logic [4:0] lwa,
                       input logic lf, input logic [31:0] lwd);
    rec_t r;
    bit   busy;
    bit   drn;
    bit   acc;
    ent_t e;
    @(posedge clock);
    #1;
    pipe_wen = pw; pipe_wa = pwa; pipe_float = pf; pipe_wd = pwd;
    lu_valid = lv; lu_wa = lwa; lu_float = lf; lu_wd = lwd;
    busy    = pw && (pwa != 5'd0);
    r.rdy   = (mq.size() < DEPTH);
    r.cnt   = mq.size();
    r.stall = stallExp;
    r.mask  = maskOf();
    if (busy) begin
      r.wen = 1'b1; r.wa = pwa; r.wd = pwd; r.fl = pf;
    end else if (mq.size() > 0) begin
      r.wen = 1'b1; r.wa = mq[0].wa; r.wd = mq[0].wd; r.fl = mq[0].fl;
    end else begin
      r.wen = pw; r.wa = pwa; r.wd = pwd; r.fl = pf;
    end
    expQ.push_back(r);
    monEn = 1'b1;
    drn = !busy && (mq.size() > 0);
    acc = lv && r.rdy;
    if (r.cnt == 0 || drn) begin
      runLen   = 0;
      stallExp = 1'b0;
    end else begin
      runLen++;
      if (runLen >= int'(STARVE_LIMIT)) stallExp = 1'b1;
    end
    if (drn) void'(mq.pop_front());
    if (acc && lwa != 5'd0) begin
      e.wa = lwa; e.fl = lf; e.wd = lwd;
      mq.push_back(e);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic busyCycle(input logic [31:0] d);
    cycle(1'b1, 5'd9, 1'b0, d, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  // Scoreboard monitor: compares every cycle mid-period
  rec_t mr;
  initial begin
    forever begin
      @(negedge clock);
      if (monEn) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: no expected record at %0t", $time);
        end else begin
          mr = expQ.pop_front();
          if (wen !== mr.wen || wa !== mr.wa || wd !== mr.wd || floatingWB !== mr.fl ||
              lu_ready !== mr.rdy || int'(fifo_count) != mr.cnt || stall_req !== mr.stall ||
              dutMask !== mr.mask) begin
            errors++;
            $display("FAIL port_cycle@%0t: got wen=%b wa=%0d wd=%h fb=%b rdy=%b cnt=%0d stall=%b mask=%h expected wen=%b wa=%0d wd=%h fb=%b rdy=%b cnt=%0d stall=%b mask=%h",
                     $time, wen, wa, wd, floatingWB, lu_ready, fifo_count, stall_req, dutMask,
                     mr.wen, mr.wa, mr.wd, mr.fl, mr.rdy, mr.cnt, mr.stall, mr.mask);
          end
        end
      end
    end
  end

  // Let the last queued record be checked, then stop the monitor
  task automatic quiesce();
    @(negedge clock);
    #1;
    monEn = 1'b0;
  endtask

  bit          pend;
  logic [4:0]  pWa;
  logic        pFl;
  logic [31:0] pWd;
  bit          rdyNow;
  int          busyPct;
  int          guard;

  initial begin
    // Reset state
    #2;
    chk("reset_wen", 64'(wen), 64'd0);
    chk("reset_count", 64'(fifo_count), 64'd0);
    chk("reset_lu_ready", 64'(lu_ready), 64'd0);
    chk("reset_stall", 64'(stall_req), 64'd0);
    #10;
    reset = 1'b1;
    #1;
    chk("post_reset_lu_ready", 64'(lu_ready), 64'd1);

    // Free-slot drain
    cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd5, 1'b1, 32'h3F800000);
    idle(); idle();

    // Pipe priority, then drain on pipe_wa==0
    cycle(1'b1, 5'd3, 1'b0, 32'h11, 1'b1, 5'd7, 1'b0, 32'hAA);
    cycle(1'b1, 5'd3, 1'b0, 32'h11, 1'b0, 5'd0, 1'b0, 32'd0);
    cycle(1'b1, 5'd3, 1'b0, 32'h11, 1'b0, 5'd0, 1'b0, 32'd0);
    cycle(1'b1, 5'd0, 1'b1, 32'h22, 1'b0, 5'd0, 1'b0, 32'd0);
    idle();

    // Full boundary: five pushes behind a busy pipe, fifth waits for space
    for (int k = 1; k <= 4; k++)
      cycle(1'b1, 5'd9, 1'b0, 32'(k), 1'b1, 5'(k), 1'b0, 32'(100 + k));
    guard = 0;
    do begin
      rdyNow = (mq.size() < DEPTH);
      if (guard < 3) cycle(1'b1, 5'd9, 1'b0, 32'd55, 1'b1, 5'd5, 1'b0, 32'd105);
      else           cycle(1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd5, 1'b0, 32'd105);
      guard++;
    end while (!rdyNow && guard < 20);
    chk("fifth_accepted", 64'(rdyNow), 64'd1);
    repeat (6) idle();

    // Starvation with a single entry, then a bubble drains it
    cycle(1'b1, 5'd4, 1'b0, 32'd1, 1'b1, 5'd6, 1'b0, 32'h66);
    for (int k = 0; k < 10; k++) busyCycle(32'(k));
    idle(); idle();

    // Long starvation to exercise counter saturation
    cycle(1'b1, 5'd4, 1'b0, 32'd1, 1'b1, 5'd6, 1'b1, 32'h77);
    for (int k = 0; k < 300; k++) busyCycle(32'(k));
    idle(); idle();

    // x0 results are dropped; a real one is queued and tracked
    cycle(1'b1, 5'd8, 1'b0, 32'd3, 1'b1, 5'd0, 1'b1, 32'hDEAD);
    cycle(1'b1, 5'd8, 1'b0, 32'd3, 1'b1, 5'd2, 1'b0, 32'hBEEF);
    busyCycle(32'd4); busyCycle(32'd5);
    idle(); idle();

    // Reset mid-operation with three queued results
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 5'd9, 1'b0, 32'd7, 1'b1, 5'(10 + k), 1'b0, 32'(200 + k));
    quiesce();
    reset = 1'b0;
    #1;
    chk("midreset_wen", 64'(wen), 64'd0);
    chk("midreset_count", 64'(fifo_count), 64'd0);
    chk("midreset_stall", 64'(stall_req), 64'd0);
    chk("midreset_lu_ready", 64'(lu_ready), 64'd0);
    @(posedge clock);
    #2;
    pipe_wen = 1'b0; pipe_wa = '0; lu_valid = 1'b0; lu_wa = '0;
    reset = 1'b1;
    #1;
    chk("release_lu_ready", 64'(lu_ready), 64'd1);
    chk("release_count", 64'(fifo_count), 64'd0);
    mq.delete();
    expQ.delete();
    runLen = 0;
    stallExp = 1'b0;

    // Randomized traffic with phases of light, medium and heavy pipe load
    pend = 1'b0; pWa = '0; pFl = 1'b0; pWd = '0;
    for (int ph = 0; ph < 12; ph++) begin
      busyPct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 97);
      for (int n = 0; n < 250; n++) begin
        logic        pw;
        logic [4:0]  pa;
        if (!pend && $urandom_range(99) < 55) begin
          pend = 1'b1;
          pWa  = ($urandom_range(99) < 12) ? 5'd0 : 5'($urandom_range(31));
          pFl  = 1'($urandom);
          pWd  = $urandom;
        end
        pw = ($urandom_range(99) < busyPct);
        pa = ($urandom_range(99) < 8) ? 5'd0 : 5'($urandom_range(1, 31));
        rdyNow = (mq.size() < DEPTH);
        cycle(pw, pa, 1'($urandom), $urandom, pend, pWa, pFl, pWd);
        if (pend && rdyNow) pend = 1'b0;
      end
    end
    lu_valid = 1'b0;
    repeat (10) idle();
    quiesce();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
